mux_nx1_reg: RTL and testbench
==============================

MUX_NX1_REG -- requirements
Module: mux_nx1_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data width per channel in bits (>=1).
REQ-002 The block SHALL have parameter N, default 4, number of input channels (2..16).
REQ-003 The block SHALL define SELW = clog2(N) as a derived localparam.
REQ-004 Port clk  input  1  rising-edge clock; the only clock.
REQ-005 Port rst_n  input  1  reset, synchronous, active-low.
REQ-006 Port mode  input  1  0 = manual select, 1 = round-robin scan.
REQ-007 Port sel  input  SELW  manual-mode channel index.
REQ-008 Port in_data  input  N*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 Port in_valid  input  N  per-channel valid.
REQ-010 Port in_ready  output  N  per-channel ready, one-hot or zero.
REQ-011 Port out_data  output  WIDTH  registered selected data.
REQ-012 Port out_ch  output  SELW  channel index of the word in out_data.
REQ-013 Port out_valid  output  1  output register holds a word.
REQ-014 Port out_ready  input  1  downstream accepts.
REQ-015 Port sel_err  output  1  sticky flag: manual sel >= N was seen.

Function
REQ-016 The output register SHALL implement a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 The block SHALL set can_load = EMPTY or (FULL and out_ready).
REQ-018 In manual mode, the block SHALL grant channel sel when can_load, in_valid[sel] and sel < N.
REQ-019 In round-robin mode, the block SHALL grant the first channel with in_valid set, searching from rr_ptr upward modulo N, when can_load.
REQ-020 in_ready[g] SHALL be 1 only for granted channel g; all other bits SHALL be 0 in the same cycle (combinational from state and inputs).
REQ-021 On a grant, the block SHALL load out_data = channel g data and out_ch = g at the next edge; latency is 1 cycle from handshake to out_valid.
REQ-022 The FSM SHALL transition EMPTY->FULL on grant; FULL->EMPTY on out_ready with no grant; FULL stays FULL on out_ready with grant (back-to-back, one word per cycle).
REQ-023 In FULL with out_ready=0, out_data and out_ch SHALL hold, and in_ready SHALL be all zero.
REQ-024 On each round-robin grant, rr_ptr SHALL become (g+1) mod N, wrapping N-1 -> 0. Manual grants SHALL NOT change rr_ptr.
REQ-025 With no valid input in round-robin mode, there SHALL be no grant and rr_ptr SHALL hold.
REQ-026 A mode change SHALL take effect in the same cycle; a word already in the output register is unaffected.
REQ-027 Manual sel >= N (N not a power of two) SHALL produce no grant and SHALL set sel_err; sel_err clears only on reset.

Reset
REQ-028 While rst_n=0 at a clock edge, the block SHALL set: FSM=EMPTY, out_valid=0, out_data=0, out_ch=0, rr_ptr=0, sel_err=0.
REQ-029 Reset SHALL override any concurrent grant or drain; a word held in FULL is discarded.
REQ-030 in_ready SHALL be all zero during reset.

Configuration
REQ-031 Macro MUX_PARITY_EN defined: the block SHALL add output out_par (1 bit), registered with out_data, equal to the even parity (XOR reduction) of the loaded word; reset value 0.
REQ-032 Macro MUX_PARITY_EN undefined: out_par SHALL be absent, with no other change.

Structure
REQ-033 Package mux_pkg SHALL hold the FSM state typedef (EMPTY, FULL) and the mode encodings MODE_MANUAL=0, MODE_RR=1.
REQ-034 The round-robin search SHALL be a sub-module rr_arbiter (inputs req[N] and ptr; outputs gnt_vld and gnt_idx), purely combinational.

Verification
REQ-035 N=4, WIDTH=8, manual, sel=0, in_data ch0=0x55, ch1=0xAA, in_valid=4'b0011, out_ready=1 -> in_ready=4'b0001; next cycle out_data=0x55, out_ch=0.
REQ-036 Same setup with sel=1 -> out_data=0xAA, out_ch=1 one cycle later.
REQ-037 Round-robin, in_valid=4'b1111, out_ready=1, ch k data=0x10+k -> out_ch sequence 0,1,2,3,0 on consecutive cycles, with no bubbles.
REQ-038 Round-robin, in_valid=4'b1010, rr_ptr=2 -> grants ch3, then ch1 (wrap), then ch3.
REQ-039 FULL with out_data=0x55 and out_ready=0 for 3 cycles -> out_data holds 0x55, in_ready=0; then out_ready=1 with a new grant -> next word loaded the following cycle.
REQ-040 N=3, manual, sel=3 -> no grant, sel_err=1 next cycle; rst_n=0 mid-FULL -> out_valid=0, sel_err=0 after the edge.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types for the registered N:1 multiplexer.
// Output-register state and the mode encodings.
package mux_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

endpackage

// File: rtl/mux_nx1_reg_rr_arbiter.sv
// Combinational round-robin search.
// Finds the first requester at or above ptr, modulo N.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_vld,
  output logic [SELW-1:0] gnt_idx
);

  // Walk N candidates starting at ptr; the first hit wins.
  always_comb begin
    int j;
    j       = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!gnt_vld && req[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = SELW'(j);
      end
    end
  end

endmodule

// File: rtl/mux_nx1_reg.sv
// Registered N:1 mux, manual or round-robin select.
// Optional MUX_PARITY_EN adds out_par (XOR of loaded word).
module mux_nx1_reg
  import mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_ch,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_err
`ifdef MUX_PARITY_EN
  ,
  output logic               out_par
`endif
);

  localparam int SELN = 1 << SELW;
  localparam logic [SELN-1:0] SEL_MASK =
    SELN'((64'd1 << N) - 64'd1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [SELW-1:0]   ch_q, ch_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  logic              err_q, err_d;

  logic [SELN-1:0]   valid_pad;
  logic              sel_ok;
  logic              man_req;
  logic              rr_vld;
  logic [SELW-1:0]   rr_idx;
  logic              can_load;
  logic              gnt;
  logic [SELW-1:0]   gnt_idx;
  logic [WIDTH-1:0]  gnt_data;

  assign valid_pad = SELN'(in_valid);
  assign sel_ok    = SEL_MASK[sel];
  assign man_req   = valid_pad[sel] & sel_ok;

  rr_arbiter #(
    .N(N)
  ) u_rr (
    .req    (in_valid),
    .ptr    (ptr_q),
    .gnt_vld(rr_vld),
    .gnt_idx(rr_idx)
  );

  // Grant decision; reset suppresses every grant.
  always_comb begin
    can_load = (state_q == EMPTY) || out_ready;
    gnt      = 1'b0;
    gnt_idx  = sel;
    unique case (1'b1)
      (mode == MODE_RR): begin
        gnt     = rst_n && can_load && rr_vld;
        gnt_idx = rr_idx;
      end
      default: begin
        gnt     = rst_n && can_load && man_req;
        gnt_idx = sel;
      end
    endcase
  end

  // One-hot ready toward the granted channel only.
  always_comb begin
    in_ready = '0;
    if (gnt) in_ready[gnt_idx] = 1'b1;
  end

  // Select the granted channel's word.
  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt_idx == SELW'(k))
        gnt_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  // Output-register occupancy FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (gnt) state_d = FULL;
      FULL:  if (out_ready && !gnt) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Datapath, scan pointer and sticky error next-state.
  always_comb begin
    data_d = data_q;
    ch_d   = ch_q;
    ptr_d  = ptr_q;
    err_d  = err_q;
    if (gnt) begin
      data_d = gnt_data;
      ch_d   = gnt_idx;
    end
    if (gnt && mode == MODE_RR) begin
      ptr_d = (rr_idx == SELW'(N - 1)) ?
              '0 : rr_idx + 1'b1;
    end
    if (mode == MODE_MANUAL && !sel_ok)
      err_d = 1'b1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

`ifdef MUX_PARITY_EN
  logic par_q, par_d;

  // Parity follows the word into the register.
  always_comb begin
    par_d = par_q;
    if (gnt) par_d = ^gnt_data;
  end

  // Parity register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end

  assign out_par = par_q;
`endif

  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_valid = (state_q == FULL);
  assign sel_err   = err_q;

endmodule

// File: tb/tb_mux_nx1_reg.sv
// Scoreboard bench for mux_nx1_reg (N=4 random, N=3 directed).
// Expected words are queued at grant time and popped on drain.
module tb_mux_nx1_reg;

  localparam int N = 4;
  localparam int W = 8;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
  logic        sel_err;

  logic        rst3_n;
  logic        mode3;
  logic [1:0]  sel3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_valid3;
  logic        out_ready3;
  logic        sel_err3;
`ifdef MUX_PARITY_EN
  logic        out_par;
  logic        out_par3;
`endif

  mux_nx1_reg #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready), .sel_err(sel_err)
`ifdef MUX_PARITY_EN
    , .out_par(out_par)
`endif
  );

  mux_nx1_reg #(.WIDTH(W), .N(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .mode(mode3), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .out_data(out_data3),
    .out_ch(out_ch3), .out_valid(out_valid3),
    .out_ready(out_ready3), .sel_err(sel_err3)
`ifdef MUX_PARITY_EN
    , .out_par(out_par3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         ch;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   m_full;
  int   m_ptr;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Reference: which channel the rules say should win.
  function automatic int model_pick(input bit md,
                                    input int s,
                                    input logic [3:0] v);
    if (!md) return (s < N && v[s]) ? s : -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic step(input bit md, input int s,
                      input logic [3:0] v,
                      input logic [31:0] d,
                      input bit ordy);
    int g;
    exp_t e;
    @(posedge clk);
    #2;
    chk("out_valid", 32'(out_valid), 32'(m_full));
    if (m_full && sb.size() > 0) begin
      chk("hold_data", 32'(out_data), 32'(sb[0].d));
      chk("hold_ch", 32'(out_ch), sb[0].ch);
    end
    chk("sel_err", 32'(sel_err), 32'd0);
    mode      = md;
    sel       = s[1:0];
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    g = model_pick(md, s, v);
    if (m_full && !ordy) g = -1;
    #1;
    chk("in_ready", 32'(in_ready),
        (g < 0) ? 32'd0 : (32'd1 << g));
    if (g >= 0) begin
      e.d  = d[g*8 +: 8];
      e.ch = g;
      sb.push_back(e);
      if (md) m_ptr = (g + 1) % N;
    end
    m_full = (g >= 0) || (m_full && !ordy);
  endtask

  // Monitor: a word leaves when valid and ready meet.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("mon_data", 32'(out_data), 32'(e.d));
          chk("mon_ch", 32'(out_ch), e.ch);
`ifdef MUX_PARITY_EN
          chk("mon_par", 32'(out_par), 32'(^e.d));
`endif
        end
      end
    end
  end

  initial begin
    logic [31:0] d35;
    logic [31:0] drr;
    mode = 0; sel = 0; in_data = 0; in_valid = 0;
    out_ready = 0; rst_n = 0;
    rst3_n = 0; mode3 = 0; sel3 = 0; in_data3 = 0;
    in_valid3 = 0; out_ready3 = 0;
    m_full = 0; m_ptr = 0;
    d35 = 32'h0000AA55;
    drr = 32'h13121110;

    @(posedge clk); #2;
    mode = 1; in_valid = 4'hf; out_ready = 1;
    in_data = drr;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ch", 32'(out_ch), 32'd0);
    chk("rst_err", 32'(sel_err), 32'd0);
    in_valid = 0;
    rst_n = 1;

    step(0, 0, 4'b0011, d35, 1);
    step(0, 1, 4'b0011, d35, 1);
    step(0, 0, 4'b0000, d35, 1);

    for (int i = 0; i < 5; i++)
      step(1, 0, 4'hf, drr, 1);
    step(1, 0, 4'hf, drr, 1);
    for (int i = 0; i < 3; i++)
      step(1, 0, 4'b1010, drr, 1);
    step(1, 0, 4'b0000, drr, 1);
    step(1, 0, 4'b0000, drr, 1);

    step(0, 0, 4'b0011, d35, 1);
    for (int i = 0; i < 3; i++)
      step(0, 1, 4'b0011, d35, 0);
    step(0, 1, 4'b0011, d35, 1);
    step(0, 0, 4'b0000, d35, 1);

    step(1, 0, 4'b0100, drr, 0);
    step(1, 0, 4'b0000, drr, 0);
    @(posedge clk); #2;
    rst_n = 0; in_valid = 4'hf;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #2;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", 32'(out_data), 32'd0);
    chk("midrst_ch", 32'(out_ch), 32'd0);
    sb.delete();
    m_full = 0; m_ptr = 0;
    rst_n = 1; in_valid = 0;

    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)),
           4'($urandom), $urandom,
           ($urandom_range(0, 9) < 7));
    end
    for (int i = 0; i < 3; i++)
      step(1, 0, 4'b0000, drr, 1);
    @(negedge clk); #1;
    chk("sb_drained", sb.size(), 32'd0);

    @(posedge clk); #2;
    rst3_n = 1; mode3 = 0; sel3 = 2'd3;
    in_valid3 = 3'b111; in_data3 = 24'h332211;
    out_ready3 = 1;
    #1;
    chk("n3_bad_sel_ready", 32'(in_ready3), 32'd0);
    @(posedge clk); #2;
    chk("n3_sel_err", 32'(sel_err3), 32'd1);
    chk("n3_no_load", 32'(out_valid3), 32'd0);
    sel3 = 2'd0; out_ready3 = 0;
    #1;
    chk("n3_ready_ch0", 32'(in_ready3), 32'd1);
    @(posedge clk); #2;
    chk("n3_full", 32'(out_valid3), 32'd1);
    chk("n3_data", 32'(out_data3), 32'h11);
    chk("n3_err_sticky", 32'(sel_err3), 32'd1);
    chk("n3_stall_ready", 32'(in_ready3), 32'd0);
    rst3_n = 0;
    @(posedge clk); #2;
    chk("n3_rst_valid", 32'(out_valid3), 32'd0);
    chk("n3_rst_err", 32'(sel_err3), 32'd0);
    chk("n3_rst_data", 32'(out_data3), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
